bcd_timer_ctrl: RTL

Run controller for the multi-decade BCD counter chain. It turns start/stop/clear/lap commands into the chain's single-cycle `enable` and a synchronous clear request, and divides `clk` with a prescaler to set the count rate. It also watches the chain's BCD value for a programmable target match and detects full-scale rollover. It sits between the user/command logic and the counter chain, and drives the chain's enable and clear.

---
 rtl/bcd_timer_ctrl_if.sv | 31 +++
 rtl/bcd_timer_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/bcd_timer_ctrl_if.sv
// Command, status and chain-facing signals of the BCD timer run controller.
interface bcd_timer_ctrl_if #(
    parameter int unsigned N = 3
) ();
    localparam int unsigned W = 4 * N;

    logic         start;
    logic         stop;
    logic         clear;
    logic         lap;
    logic [W-1:0] target;
    logic [W-1:0] cnt_q;
    logic         cnt_fdone;
    logic         cnt_enable;
    logic         cnt_clear;
    logic [W-1:0] lap_q;
    logic         lap_valid;
    logic         alarm;
    logic         overflow;
    logic [1:0]   state;

    modport master (
        output start, stop, clear, lap, target, cnt_q, cnt_fdone,
        input  cnt_enable, cnt_clear, lap_q, lap_valid, alarm, overflow, state
    );

    modport slave (
        input  start, stop, clear, lap, target, cnt_q, cnt_fdone,
        output cnt_enable, cnt_clear, lap_q, lap_valid, alarm, overflow, state
    );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Run controller for a multi-decade BCD counter chain: start/stop/clear/lap
// commands, prescaled count enable, target match and full-scale rollover.
module bcd_timer_ctrl #(
    parameter int unsigned N        = 3,
    parameter int unsigned PRESCALE = 10
) (
    input  logic            clk,
    input  logic            reset,
    bcd_timer_ctrl_if.slave bus
);
    localparam int unsigned W  = 4 * N;
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  lap_cap_q, lap_cap_d;
    logic          lap_valid_q, lap_valid_d;
    logic          alarm_q, alarm_d;
    logic          overflow_q, overflow_d;

    logic match_c;
    logic tick_c;
    logic run_c;
    logic en_c;

    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            lap_cap_q   <= '0;
            lap_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            lap_cap_q   <= lap_cap_d;
            lap_valid_q <= lap_valid_d;
            alarm_q     <= alarm_d;
            overflow_q  <= overflow_d;
        end
    end

    // Next-state, prescaler and enable decode; priority clear > stop > start
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        lap_cap_d   = lap_cap_q;
        lap_valid_d = lap_valid_q;
        alarm_d     = alarm_q;
        overflow_d  = overflow_q;

        match_c = (bus.target != '0) && (bus.cnt_q == bus.target);
        tick_c  = (presc_q == PW'(PRESCALE - 1));
        run_c   = (state_q == ST_RUN);
        en_c    = tick_c & run_c & ~match_c & ~bus.stop & ~bus.clear;

        // Prescaler advances in every RUN cycle, so a pause keeps the tick phase
        if (run_c) begin
            presc_d = tick_c ? '0 : presc_q + PW'(1);
        end

        if (bus.clear) begin
            state_d     = ST_IDLE;
            presc_d     = '0;
            lap_cap_d   = '0;
            lap_valid_d = 1'b0;
            alarm_d     = 1'b0;
            overflow_d  = 1'b0;
        end else begin
            if (bus.lap && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
                lap_cap_d   = bus.cnt_q;
                lap_valid_d = 1'b1;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_PAUSE;
                    end else if (match_c) begin
                        state_d = ST_DONE;
                        alarm_d = 1'b1;
                    end else if (en_c && bus.cnt_fdone) begin
                        state_d    = ST_DONE;
                        overflow_d = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
            endcase
        end
    end

    assign bus.cnt_enable = en_c;
    assign bus.cnt_clear  = bus.clear & ~reset;
    assign bus.lap_q      = lap_cap_q;
    assign bus.lap_valid  = lap_valid_q;
    assign bus.alarm      = alarm_q;
    assign bus.overflow   = overflow_q;
    assign bus.state      = state_q;
endmodule
